// File: rtl/tetris_key_pkg.sv
// Shared definitions for the Tetris key-input conditioner: HID keycodes,
// the per-channel DAS state encoding, the action bundle, and the
// keycode-to-action decode. The decode maps the HID arrow keys onto the
// WASD channels only when TETRIS_KEYIN_ARROWS_EN is defined.
package tetris_key_pkg;

    // HID usage codes the conditioner understands
    localparam logic [7:0] KC_NONE        = 8'h00;
    localparam logic [7:0] KC_ROLLOVER    = 8'h01;
    localparam logic [7:0] KC_LEFT        = 8'h04;
    localparam logic [7:0] KC_RIGHT       = 8'h07;
    localparam logic [7:0] KC_DOWN        = 8'h16;
    localparam logic [7:0] KC_ROT         = 8'h1A;
    localparam logic [7:0] KC_START       = 8'h28;
    localparam logic [7:0] KC_DROP        = 8'h2C;
    localparam logic [7:0] KC_ARROW_RIGHT = 8'h4F;
    localparam logic [7:0] KC_ARROW_LEFT  = 8'h50;
    localparam logic [7:0] KC_ARROW_DOWN  = 8'h51;
    localparam logic [7:0] KC_ARROW_UP    = 8'h52;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } das_state_t;

    typedef struct packed {
        logic left;
        logic right;
        logic down;
        logic rotate;
        logic drop;
        logic start;
    } action_t;

    // Map one keycode slot to the action it requests (empty and unmapped
    // codes request nothing).
    function automatic action_t decode_slot(input logic [7:0] code);
        action_t a;
        a = '0;
        case (code)
            KC_LEFT:        a.left   = 1'b1;
            KC_RIGHT:       a.right  = 1'b1;
            KC_DOWN:        a.down   = 1'b1;
            KC_ROT:         a.rotate = 1'b1;
            KC_DROP:        a.drop   = 1'b1;
            KC_START:       a.start  = 1'b1;
`ifdef TETRIS_KEYIN_ARROWS_EN
            KC_ARROW_LEFT:  a.left   = 1'b1;
            KC_ARROW_RIGHT: a.right  = 1'b1;
            KC_ARROW_DOWN:  a.down   = 1'b1;
            KC_ARROW_UP:    a.rotate = 1'b1;
`endif
            default:        a = '0;
        endcase
        return a;
    endfunction

    // Pick the single keycode the controller sees when several actions fire
    // in one frame: start beats drop beats rotate beats the moves.
    function automatic logic [7:0] action_keycode(input action_t fire);
        logic [7:0] kc;
        kc = KC_NONE;
        if (fire.start)       kc = KC_START;
        else if (fire.drop)   kc = KC_DROP;
        else if (fire.rotate) kc = KC_ROT;
        else if (fire.left)   kc = KC_LEFT;
        else if (fire.right)  kc = KC_RIGHT;
        else if (fire.down)   kc = KC_DOWN;
        return kc;
    endfunction

endpackage

// File: rtl/tetris_das_channel.sv
// One delayed-auto-shift channel: fires on a fresh press, again after
// DAS_FRAMES frames, then every ARR_FRAMES frames while held. Advances only
// on tick; fire is valid only in the tick cycle.
module tetris_das_channel
    import tetris_key_pkg::*;
#(
    parameter int DAS_FRAMES = 10,
    parameter int ARR_FRAMES = 3,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic press,
    output logic fire
);

    // Counter values at which the delay and repeat intervals expire.
    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_FRAMES - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_FRAMES - 1);

    das_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // State register with synchronous active-low reset.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking = here would chain flops into combinational paths.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update, evaluated once per frame tick.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (press) begin
                        state_d = DELAY;
                        cnt_d   = '0;
                    end
                end
                DELAY: begin
                    if (!press) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DAS_LAST) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!press) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == ARR_LAST) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Fire decode: fresh press, DAS expiry, or ARR expiry while held.
    always_comb begin
        fire = 1'b0;
        if (tick && press) begin
            case (state_q)
                IDLE:    fire = 1'b1;
                DELAY:   fire = (cnt_q == DAS_LAST);
                REPEAT:  fire = (cnt_q == ARR_LAST);
                default: fire = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/tetris_key_input.sv
// Conditions four HID keycode slots into per-frame Tetris actions for the
// vsync-clocked game controller. vsync is synchronized into clk and turned
// into frame_tick; all key state advances only on frame_tick, and the
// action outputs are registered for the whole following frame.
// Optional: define TETRIS_KEYIN_ARROWS_EN to alias HID arrow keys onto
// the left/right/down/rotate channels.
module tetris_key_input
    import tetris_key_pkg::*;
#(
    parameter int DAS_FRAMES = 10,
    parameter int ARR_FRAMES = 3,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic [31:0] keycode,
    output logic        frame_tick,
    output logic [7:0]  keycode_out,
    output logic        act_left,
    output logic        act_right,
    output logic        act_down,
    output logic        act_rotate,
    output logic        act_drop,
    output logic        act_start
);

    logic       vsync_meta_q, vsync_meta_d;
    logic       vsync_sync_q, vsync_sync_d;
    logic       vsync_prev_q, vsync_prev_d;
    logic       frame_tick_q, frame_tick_d;
    action_t    pressed_q,    pressed_d;
    action_t    act_q,        act_d;
    logic [7:0] keycode_out_q, keycode_out_d;

    action_t    raw_pressed;
    action_t    pressed;
    action_t    fire;
    logic       rollover;
    logic       eff_left, eff_right;
    logic       fire_left, fire_right, fire_down;

    // Two-flop synchronizer plus edge detect for the foreign-domain vsync.
    always_comb begin
        vsync_meta_d = vsync;
        vsync_sync_d = vsync_meta_q;
        vsync_prev_d = vsync_sync_q;
        frame_tick_d = vsync_sync_q & ~vsync_prev_q;
    end

    // Sample the four slots; ErrorRollOver freezes the pressed vector.
    always_comb begin
        raw_pressed = '0;
        rollover    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keycode[i*8 +: 8] == KC_ROLLOVER) rollover = 1'b1;
            raw_pressed = raw_pressed | decode_slot(keycode[i*8 +: 8]);
        end
        pressed   = rollover ? pressed_q : raw_pressed;
        // Opposing moves cancel so neither side auto-shifts.
        eff_left  = pressed.left  & ~pressed.right;
        eff_right = pressed.right & ~pressed.left;
        pressed_d = frame_tick_q ? pressed : pressed_q;
    end

    tetris_das_channel #(
        .DAS_FRAMES (DAS_FRAMES),
        .ARR_FRAMES (ARR_FRAMES),
        .CNT_W      (CNT_W)
    ) u_das_left (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (frame_tick_q),
        .press   (eff_left),
        .fire    (fire_left)
    );

    tetris_das_channel #(
        .DAS_FRAMES (DAS_FRAMES),
        .ARR_FRAMES (ARR_FRAMES),
        .CNT_W      (CNT_W)
    ) u_das_right (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (frame_tick_q),
        .press   (eff_right),
        .fire    (fire_right)
    );

    tetris_das_channel #(
        .DAS_FRAMES (DAS_FRAMES),
        .ARR_FRAMES (ARR_FRAMES),
        .CNT_W      (CNT_W)
    ) u_das_down (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (frame_tick_q),
        .press   (pressed.down),
        .fire    (fire_down)
    );

    // Gather this frame's firings and latch them for the whole frame.
    always_comb begin
        fire        = '0;
        fire.left   = fire_left;
        fire.right  = fire_right;
        fire.down   = fire_down;
        fire.rotate = frame_tick_q & pressed.rotate & ~pressed_q.rotate;
        fire.drop   = frame_tick_q & pressed.drop   & ~pressed_q.drop;
        fire.start  = frame_tick_q & pressed.start  & ~pressed_q.start;
        act_d         = frame_tick_q ? fire                 : act_q;
        keycode_out_d = frame_tick_q ? action_keycode(fire) : keycode_out_q;
    end

    // All registers of the block, synchronously reset to the idle frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vsync_meta_q  <= 1'b0;
            vsync_sync_q  <= 1'b0;
            vsync_prev_q  <= 1'b0;
            frame_tick_q  <= 1'b0;
            pressed_q     <= '0;
            act_q         <= '0;
            keycode_out_q <= KC_NONE;
        end else begin
            vsync_meta_q  <= vsync_meta_d;
            vsync_sync_q  <= vsync_sync_d;
            vsync_prev_q  <= vsync_prev_d;
            frame_tick_q  <= frame_tick_d;
            pressed_q     <= pressed_d;
            act_q         <= act_d;
            keycode_out_q <= keycode_out_d;
        end
    end

    assign frame_tick  = frame_tick_q;
    assign keycode_out = keycode_out_q;
    assign act_left    = act_q.left;
    assign act_right   = act_q.right;
    assign act_down    = act_q.down;
    assign act_rotate  = act_q.rotate;
    assign act_drop    = act_q.drop;
    assign act_start   = act_q.start;

endmodule
